// File: rtl/mdu_seq_pkg.sv
// ============================================================
// mdu_defs : shared multiply/divide op and state encodings
// Rev 1.0
// ============================================================
`default_nettype none

package mdu_defs;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } mdu_state_e;

   function automatic logic mdu_is_div(input logic [1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic mdu_is_signed(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ============================================================
// mdu_seq_if : decode <-> multiply/divide sequencer bus
// Rev 1.0
// ============================================================
`default_nettype none

interface mdu_seq_if
   import mdu_defs::*;
#(
   parameter int WIDTH = MDU_WIDTH
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );

endinterface

`default_nettype wire

// File: rtl/mdu_seq_step.sv
// ============================================================
// mdu_step : one shift-add multiply or restoring divide iteration
// Rev 1.0
// ============================================================
`default_nettype none

module mdu_step
   import mdu_defs::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  wire logic               i_is_div,
   input  wire logic [2*WIDTH-1:0] i_acc,
   input  wire logic [WIDTH-1:0]   i_opnd,
   output logic      [2*WIDTH-1:0] o_acc_next
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   always_comb begin
      w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
      // Remainder after the left shift can need one extra bit before the trial subtract.
      w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
      w_ge     = (w_rem_sh >= {1'b0, i_opnd});
      w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;
      if (i_is_div) begin
         if (w_ge) o_acc_next = {w_diff, i_acc[WIDTH-2:0], 1'b1};
         else      o_acc_next = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else if (i_acc[0]) begin
         o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         o_acc_next = {1'b0, i_acc[2*WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================
// mdu_seq : iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Rev 1.0
// ============================================================
`default_nettype none

module mdu_seq
   import mdu_defs::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input wire logic  clk,
   input wire logic  rstn,
   mdu_seq_if.slave  bus
);

   localparam int c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   mdu_state_e         r_state, w_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [1:0]         r_op;
   logic               r_sa, r_sb, r_dz;
   logic [2*WIDTH-1:0] r_acc, w_acc_next, w_prod;
   logic [WIDTH-1:0]   r_opnd, r_a, r_hi, r_lo;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quot, w_rem;
   logic               w_sa, w_sb, w_div;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div   (mdu_is_div(r_op)),
      .i_acc      (r_acc),
      .i_opnd     (r_opnd),
      .o_acc_next (w_acc_next)
   );

   always_comb begin
      w_div   = mdu_is_div(bus.op);
      w_sa    = mdu_is_signed(bus.op) & bus.a[WIDTH-1];
      w_sb    = mdu_is_signed(bus.op) & bus.b[WIDTH-1];
      w_mag_a = w_sa ? -bus.a : bus.a;
      w_mag_b = w_sb ? -bus.b : bus.b;
      // Sign flags are only ever set for signed ops, so no op check is needed here.
      w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
      w_quot  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem   = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_next = (w_div && bus.b == '0) ? S_FIX : S_CALC;
         S_CALC: if (r_cnt == c_last) w_next = S_FIX;
         S_FIX:  w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (r_state != S_IDLE && bus.flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt  <= '0;
         r_op   <= MDU_MULTU;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_dz   <= 1'b0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_a    <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_cnt  <= '0;
         r_op   <= bus.op;
         r_sa   <= w_sa;
         r_sb   <= w_sb;
         r_dz   <= w_div && (bus.b == '0);
         r_a    <= bus.a;
         r_acc  <= w_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
         r_opnd <= w_div ? w_mag_b : w_mag_a;
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_acc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == S_IDLE) begin
         if (bus.hi_we) r_hi <= bus.wdata;
         if (bus.lo_we) r_lo <= bus.wdata;
      end else if (r_state == S_FIX && !bus.flush) begin
         if (r_dz) begin
            r_hi <= r_a;
            r_lo <= '1;
         end else if (mdu_is_div(r_op)) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
         end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
         end
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = (r_state == S_DONE);
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire
